// File: rtl/mem_port_arbiter.sv
// Purpose: shares the single core memory port between instruction fetch (read-only) and load/store.
// Latency: accept at T, mem_req_o at T+1, response pulse one cycle after mem_rvalid_i (3-cycle minimum issue interval).
// Backpressure: ready only in IDLE; request held on mem_req_o until mem_gnt_i, one transaction in flight.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid_i,
    output logic        if_ready_o,
    input  logic [31:0] if_addr_i,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        flush_i,
    input  logic        ls_valid_i,
    output logic        ls_ready_o,
    input  logic [31:0] ls_addr_i,
    input  logic        ls_we_i,
    input  logic [3:0]  ls_be_i,
    input  logic [31:0] ls_wdata_i,
    output logic        ls_rvalid_o,
    output logic [31:0] ls_rdata_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RSP  = 2'd2;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0] state;
    logic [3:0] starve_cnt;
    logic       owner_if;
    logic       drop;
    logic       forced;
    logic       sel_ls;
    logic       sel_if;

    // IF is forced only when it could actually be accepted this cycle
    assign forced = if_valid_i && !flush_i && (starve_cnt == STARVE_LIM);
    assign sel_ls = (state == IDLE) && ls_valid_i && !forced;
    assign sel_if = (state == IDLE) && !sel_ls && if_valid_i && !flush_i;

    assign ls_ready_o = sel_ls;
    assign if_ready_o = sel_if;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            starve_cnt  <= 4'd0;
            owner_if    <= 1'b0;
            drop        <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'd0;
            mem_wdata_o <= 32'd0;
            if_rvalid_o <= 1'b0;
            if_rdata_o  <= 32'd0;
            ls_rvalid_o <= 1'b0;
            ls_rdata_o  <= 32'd0;
        end else begin
            if_rvalid_o <= 1'b0;
            ls_rvalid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_ls) begin
                        mem_req_o   <= 1'b1;
                        mem_addr_o  <= ls_addr_i;
                        mem_we_o    <= ls_we_i;
                        mem_be_o    <= ls_be_i;
                        mem_wdata_o <= ls_wdata_i;
                        owner_if    <= 1'b0;
                        state       <= REQ;
                        if (if_valid_i)
                            starve_cnt <= (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 4'd1;
                        else
                            starve_cnt <= 4'd0;
                    end else if (sel_if) begin
                        mem_req_o   <= 1'b1;
                        mem_addr_o  <= if_addr_i;
                        mem_we_o    <= 1'b0;
                        mem_be_o    <= 4'hF;
                        mem_wdata_o <= 32'd0;
                        owner_if    <= 1'b1;
                        state       <= REQ;
                        starve_cnt  <= 4'd0;
                    end
                end
                REQ: begin
                    if (owner_if && flush_i)
                        drop <= 1'b1;
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (mem_rvalid_i) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                        if (!owner_if) begin
                            ls_rvalid_o <= 1'b1;
                            ls_rdata_o  <= mem_rdata_i;
                        end else if (!drop && !flush_i) begin
                            // a flush arriving alongside the data discards it as well
                            if_rvalid_o <= 1'b1;
                            if_rdata_o  <= mem_rdata_i;
                        end
                    end else if (owner_if && flush_i) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed stimulus, memory responder model, response scoreboard.
module tb_mem_port_arbiter;
    logic        clk;
    logic        rst;
    logic        if_valid_i;
    logic        if_ready_o;
    logic [31:0] if_addr_i;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        flush_i;
    logic        ls_valid_i;
    logic        ls_ready_o;
    logic [31:0] ls_addr_i;
    logic        ls_we_i;
    logic [3:0]  ls_be_i;
    logic [31:0] ls_wdata_i;
    logic        ls_rvalid_o;
    logic [31:0] ls_rdata_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } mem_exp_t;

    typedef struct {
        logic        is_if;
        logic [31:0] data;
    } rsp_exp_t;

    mem_exp_t    exp_mem_q[$];
    rsp_exp_t    exp_rsp_q[$];
    logic        acc_q[$];
    int          n_checks = 0;
    int          n_err = 0;
    int          gnt_delay = 0;
    int          rsp_delay = 1;
    int          wait_cnt = 0;
    int          rsp_wait = 0;
    logic [31:0] rsp_data = 32'd0;

    mem_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .if_addr_i(if_addr_i),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .flush_i(flush_i),
        .ls_valid_i(ls_valid_i), .ls_ready_o(ls_ready_o), .ls_addr_i(ls_addr_i),
        .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_wdata_i(ls_wdata_i),
        .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_mem(input logic [31:0] a, input logic we, input logic [3:0] be,
                            input logic [31:0] wd, input logic [31:0] rd);
        mem_exp_t e;
        e.addr = a; e.we = we; e.be = be; e.wdata = wd; e.rdata = rd;
        exp_mem_q.push_back(e);
    endtask

    task automatic push_rsp(input logic is_if, input logic [31:0] d);
        rsp_exp_t r;
        r.is_if = is_if; r.data = d;
        exp_rsp_q.push_back(r);
    endtask

    // Both requesters held valid; pat (MSB first) lists the required grant order, 1 = IF.
    task automatic grant_seq(input logic [15:0] pat, input int n);
        int waited;
        for (int i = 0; i < n; i++) begin
            if (pat[n-1-i]) begin
                push_mem(32'h700, 1'b0, 4'hF, 32'd0, 32'h7000_0000 + i);
                push_rsp(1'b1, 32'h7000_0000 + i);
            end else begin
                push_mem(32'h600, 1'b0, 4'hF, 32'd0, 32'h6000_0000 + i);
                push_rsp(1'b0, 32'h6000_0000 + i);
            end
        end
        acc_q.delete();
        ls_addr_i = 32'h600; ls_we_i = 1'b0; ls_be_i = 4'hF; ls_wdata_i = 32'd0;
        if_addr_i = 32'h700;
        ls_valid_i = 1'b1;
        if_valid_i = 1'b1;
        waited = 0;
        while (acc_q.size() < n && waited < 20 * n) begin
            @(posedge clk);
            waited++;
        end
        #1;
        ls_valid_i = 1'b0;
        if_valid_i = 1'b0;
        chk("grant_count", 72'(acc_q.size()), 72'(n));
        for (int i = 0; i < n && i < acc_q.size(); i++)
            chk("grant_order", 72'(acc_q[i]), 72'(pat[n-1-i]));
        repeat (5) tick();
    endtask

    // Memory responder: grants after gnt_delay waiting cycles, returns data rsp_delay cycles after grant.
    initial begin
        mem_exp_t e;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
        forever begin
            @(negedge clk);
            mem_gnt_i = 1'b0;
            mem_rvalid_i = 1'b0;
            if (!rst) begin
                wait_cnt = 0;
                rsp_wait = 0;
                exp_mem_q.delete();
            end else if (rsp_wait > 0) begin
                rsp_wait--;
                if (rsp_wait == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i = rsp_data;
                end
            end else if (mem_req_o) begin
                if (exp_mem_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL mem_unexpected_req: got addr %0h required no request", mem_addr_o);
                    mem_gnt_i = 1'b1; rsp_wait = rsp_delay; rsp_data = 32'd0;
                end else begin
                    e = exp_mem_q[0];
                    if (wait_cnt == gnt_delay) begin
                        chk("mem_req_fields", 72'({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o}),
                            72'({e.addr, e.we, e.be, e.wdata}));
                        e = exp_mem_q.pop_front();
                        mem_gnt_i = 1'b1;
                        rsp_wait = rsp_delay;
                        rsp_data = e.rdata;
                        wait_cnt = 0;
                    end else begin
                        chk("mem_req_stable", 72'({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o}),
                            72'({e.addr, e.we, e.be, e.wdata}));
                        wait_cnt++;
                    end
                end
            end
        end
    end

    // Response monitor
    initial begin
        rsp_exp_t r;
        forever begin
            @(negedge clk);
            if (rst && (if_rvalid_o || ls_rvalid_o)) begin
                if (if_rvalid_o && ls_rvalid_o)
                    chk("rvalid_exclusive", 72'({if_rvalid_o, ls_rvalid_o}), 72'(2'b10));
                if (exp_rsp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL rsp_unexpected: got if_rvalid=%0d ls_rvalid=%0d required none",
                             if_rvalid_o, ls_rvalid_o);
                end else begin
                    r = exp_rsp_q.pop_front();
                    chk("rsp_port", 72'(if_rvalid_o), 72'(r.is_if));
                    chk("rsp_data", 72'(if_rvalid_o ? if_rdata_o : ls_rdata_o), 72'(r.data));
                end
            end
        end
    end

    // Grant logger
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (if_ready_o && ls_ready_o)
                    chk("ready_exclusive", 72'({if_ready_o, ls_ready_o}), 72'(2'b01));
                if (if_ready_o) acc_q.push_back(1'b1);
                else if (ls_ready_o) acc_q.push_back(1'b0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        if_valid_i = 1'b0; if_addr_i = 32'd0; flush_i = 1'b0;
        ls_valid_i = 1'b0; ls_addr_i = 32'd0; ls_we_i = 1'b0; ls_be_i = 4'd0; ls_wdata_i = 32'd0;

        // Reset state
        @(negedge clk);
        chk("reset_ctrl", 72'({mem_req_o, mem_we_o, if_rvalid_o, ls_rvalid_o}), 72'(0));
        chk("reset_mem_data", 72'({mem_addr_o, mem_be_o, mem_wdata_o}), 72'(0));
        chk("reset_rdata", 72'({if_rdata_o, ls_rdata_o}), 72'(0));
        tick();
        rst = 1'b1;
        tick();

        // IF only: accept T, req T+1, response T+3
        push_mem(32'h100, 1'b0, 4'hF, 32'd0, 32'hDEADBEEF);
        push_rsp(1'b1, 32'hDEADBEEF);
        if_valid_i = 1'b1; if_addr_i = 32'h100;
        @(negedge clk);
        chk("if_ready_T", 72'({if_ready_o, ls_ready_o}), 72'(2'b10));
        tick();
        if_valid_i = 1'b0;
        @(negedge clk);
        chk("mem_req_T1", 72'({mem_req_o, mem_we_o, mem_addr_o}), 72'({1'b1, 1'b0, 32'h100}));
        tick();
        @(negedge clk);
        chk("if_rvalid_T2", 72'(if_rvalid_o), 72'(0));
        tick();
        @(negedge clk);
        chk("if_rvalid_T3", 72'({if_rvalid_o, ls_rvalid_o, if_rdata_o}), 72'({2'b10, 32'hDEADBEEF}));
        tick();

        // LS write, grant held off 3 cycles; IF waiting must not be accepted
        gnt_delay = 3;
        push_mem(32'h2000, 1'b1, 4'b0011, 32'h1234, 32'hCAFE0001);
        push_rsp(1'b0, 32'hCAFE0001);
        push_mem(32'h300, 1'b0, 4'hF, 32'd0, 32'h0000_3300);
        push_rsp(1'b1, 32'h0000_3300);
        ls_valid_i = 1'b1; ls_addr_i = 32'h2000; ls_we_i = 1'b1; ls_be_i = 4'b0011; ls_wdata_i = 32'h1234;
        @(negedge clk);
        chk("ls_ready_T", 72'({if_ready_o, ls_ready_o}), 72'(2'b01));
        tick();
        ls_valid_i = 1'b0; ls_we_i = 1'b0;
        if_valid_i = 1'b1; if_addr_i = 32'h300;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("if_blocked", 72'(if_ready_o), 72'(0));
            if (i <= 4) chk("ls_req_held", 72'(mem_req_o), 72'(1));
            tick();
        end
        gnt_delay = 0;
        @(negedge clk);
        chk("ls_wr_rvalid", 72'({ls_rvalid_o, if_ready_o}), 72'(2'b11));
        tick();
        if_valid_i = 1'b0;
        repeat (4) tick();

        // Priority: both valid, LS first, IF at next IDLE
        push_mem(32'h40, 1'b0, 4'hF, 32'd0, 32'h1111_1111);
        push_rsp(1'b0, 32'h1111_1111);
        push_mem(32'h500, 1'b0, 4'hF, 32'd0, 32'h2222_2222);
        push_rsp(1'b1, 32'h2222_2222);
        ls_valid_i = 1'b1; ls_addr_i = 32'h40; ls_we_i = 1'b0; ls_be_i = 4'hF; ls_wdata_i = 32'd0;
        if_valid_i = 1'b1; if_addr_i = 32'h500;
        @(negedge clk);
        chk("prio_ls_wins", 72'({if_ready_o, ls_ready_o}), 72'(2'b01));
        tick();
        ls_valid_i = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("prio_if_next", 72'({if_ready_o, ls_ready_o}), 72'(2'b10));
        tick();
        if_valid_i = 1'b0;
        repeat (4) tick();

        // Starvation guard: four LS then forced IF, counter restarts from zero
        grant_seq(16'b0000_0000_0010_0001, 10);

        // Flush during RSP drops the IF response
        rsp_delay = 2;
        push_mem(32'h800, 1'b0, 4'hF, 32'd0, 32'h3333_3333);
        if_valid_i = 1'b1; if_addr_i = 32'h800;
        @(negedge clk);
        chk("flush_if_accept", 72'(if_ready_o), 72'(1));
        tick();
        if_valid_i = 1'b0;
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();
        @(negedge clk);
        chk("flush_dropped", 72'(if_rvalid_o), 72'(0));
        rsp_delay = 1;
        tick();

        // Flush in IDLE blocks IF; afterwards IF is serviced normally
        flush_i = 1'b1; if_valid_i = 1'b1; if_addr_i = 32'h900;
        @(negedge clk);
        chk("flush_idle_block", 72'(if_ready_o), 72'(0));
        tick();
        flush_i = 1'b0;
        push_mem(32'h900, 1'b0, 4'hF, 32'd0, 32'h4444_4444);
        push_rsp(1'b1, 32'h4444_4444);
        @(negedge clk);
        chk("post_flush_accept", 72'(if_ready_o), 72'(1));
        tick();
        if_valid_i = 1'b0;
        repeat (4) tick();

        // Flush while LS owns the port does not affect it
        push_mem(32'hB00, 1'b0, 4'hF, 32'd0, 32'h5555_5555);
        push_rsp(1'b0, 32'h5555_5555);
        ls_valid_i = 1'b1; ls_addr_i = 32'hB00;
        tick();
        ls_valid_i = 1'b0;
        flush_i = 1'b1;
        tick();
        tick();
        flush_i = 1'b0;
        repeat (4) tick();

        // Reset in REQ clears mem_req_o immediately; starve_cnt back to zero afterwards
        gnt_delay = 5;
        push_mem(32'hA00, 1'b0, 4'hF, 32'd0, 32'd0);
        ls_valid_i = 1'b1; ls_addr_i = 32'hA00; if_valid_i = 1'b1; if_addr_i = 32'h700;
        @(negedge clk);
        chk("rst_ls_accept", 72'(ls_ready_o), 72'(1));
        tick();
        ls_valid_i = 1'b0; if_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_req_before", 72'(mem_req_o), 72'(1));
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_req", 72'({mem_req_o, mem_addr_o}), 72'(0));
        tick();
        tick();
        rst = 1'b1;
        gnt_delay = 0;
        tick();
        grant_seq(16'b0000_0000_0000_0001, 5);

        repeat (4) tick();
        chk("mem_q_empty", 72'(exp_mem_q.size()), 72'(0));
        chk("rsp_q_empty", 72'(exp_rsp_q.size()), 72'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
